ifetch_ctrl: RTL

Instruction fetch controller for the IF stage. Owns the program counter, drives the word address of the 128-word instruction memory, and captures the returned word into the IF/ID latch (`inst`, `npc`, `inst_valid`). It sequences fetch through start, halt, stall and branch redirect, and keeps a retired-fetch counter for the lab testbenches.

---
 rtl/ifetch_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/ifetch_ctrl.sv
// IF-stage fetch controller: owns the PC, addresses instruction memory and
// fills the IF/ID latch, sequencing start/halt/stall/redirect.
module ifetch_ctrl #(
    parameter int          MEM_WORDS = 128,
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_data,
    output logic [31:0]      inst,
    output logic [31:0]      npc,
    output logic             inst_valid,
    output logic             busy,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic [31:0]      r_npc;
    logic             r_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_pc_plus1;
    logic [31:0]      w_pc_inc;
    logic [31:0]      w_redir_pc;

    // npc keeps the unwrapped pc+1; only the PC itself wraps
    assign w_pc_plus1 = r_pc + 32'd1;
    assign w_pc_inc   = (r_pc == LP_WORDS - 32'd1) ? 32'd0 : w_pc_plus1;
    assign w_redir_pc = redirect_pc % LP_WORDS;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= 32'd0;
            r_npc   <= 32'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pc    <= RESET_PC;
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redir_pc;
                        r_valid <= 1'b0;
                    end else if (stall) begin
                        r_pc    <= r_pc;
                    end else if (halt) begin
                        // pc holds: the word at pc is fetched again on resume
                        r_state <= S_HALT;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end else begin
                        r_inst  <= mem_data;
                        r_npc   <= w_pc_plus1;
                        r_valid <= 1'b1;
                        r_pc    <= w_pc_inc;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_HALT: begin
                    r_valid <= 1'b0;
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr   = r_pc;
    assign inst       = r_inst;
    assign npc        = r_npc;
    assign inst_valid = r_valid;
    assign busy       = r_busy;
    assign fetch_cnt  = r_cnt;

endmodule
